// File: rtl/alu_cmd_seq_pkg.sv
// rtl/alu_cmd_seq_pkg.sv - shared function codes, state encoding and command layout
package alu_seq_pkg;

   localparam int DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      FN_ADD  = 2'b00,
      FN_MUL  = 2'b01,
      FN_SHL  = 2'b10,
      FN_HOLD = 2'b11
   } fn_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_CLEAR = 2'b10
   } state_e;

   typedef struct packed {
      logic       clr;
      logic [2:0] rpt;
      logic [1:0] func;
      logic [3:0] data;
   } cmd_t;

endpackage

// File: rtl/alu_cmd_seq_if.sv
// rtl/alu_cmd_seq_if.sv - command handshake and downstream ALU drive bundle
interface alu_cmd_seq_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_data;
   logic [1:0] cmd_func;
   logic [2:0] cmd_repeat;
   logic       cmd_clear;
   logic [3:0] alu_data;
   logic [1:0] alu_func;
   logic       alu_clear;
   logic       busy;

   modport slave (
      input  cmd_valid, cmd_data, cmd_func, cmd_repeat, cmd_clear,
      output cmd_ready, alu_data, alu_func, alu_clear, busy
   );

   modport master (
      output cmd_valid, cmd_data, cmd_func, cmd_repeat, cmd_clear,
      input  cmd_ready, alu_data, alu_func, alu_clear, busy
   );

endinterface

// File: rtl/alu_cmd_seq_fifo.sv
// rtl/alu_cmd_seq_fifo.sv - show-ahead command FIFO with full/empty/occupancy
module cmd_fifo
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  cmd_t                     wdata,
   input  logic                     pop,
   output cmd_t                     rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   cmd_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;

endmodule

// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - queues ALU commands and replays each for its repeat count
module alu_cmd_seq
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_cmd_seq_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   cmd_t        wdata, head;
   logic        push, pop, full, empty;
   logic [AW:0] occ;

   state_e      state_q, state_d;
   logic [2:0]  rpt_q, rpt_d;
   logic [3:0]  cur_data_q, cur_data_d;
   logic [1:0]  cur_func_q, cur_func_d;
   logic        rdy_q, rdy_d;
   logic [3:0]  data_q, data_d;
   logic [1:0]  func_q, func_d;
   logic        clr_q, clr_d;
   logic        last;

   assign wdata         = {bus.cmd_clear, bus.cmd_repeat, bus.cmd_func, bus.cmd_data};
   assign bus.cmd_ready = rdy_q & ~full;
   assign push          = bus.cmd_valid & bus.cmd_ready;

   cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (occ)
   );

   // Any cycle that ends a command (or idles) may pop the next head.
   assign last = (state_q != ST_ISSUE) || (rpt_q == 3'd0);

   always_comb begin
      state_d    = state_q;
      rpt_d      = rpt_q;
      cur_data_d = cur_data_q;
      cur_func_d = cur_func_q;
      rdy_d      = 1'b1;
      pop        = 1'b0;
      if (last) begin
         if (!empty) begin
            pop = 1'b1;
            if (head.clr) begin
               state_d = ST_CLEAR;
            end else begin
               state_d    = ST_ISSUE;
               rpt_d      = head.rpt;
               cur_data_d = head.data;
               cur_func_d = head.func;
            end
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         rpt_d = rpt_q - 3'd1;
      end
   end

   // Outputs are registered from the current state, one edge behind it.
   always_comb begin
      data_d = 4'd0;
      func_d = FN_HOLD;
      clr_d  = 1'b0;
      case (state_q)
         ST_ISSUE: begin
            data_d = cur_data_q;
            func_d = cur_func_q;
         end
         ST_CLEAR: clr_d = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rpt_q      <= 3'd0;
         cur_data_q <= 4'd0;
         cur_func_q <= FN_HOLD;
         rdy_q      <= 1'b0;
         data_q     <= 4'd0;
         func_q     <= FN_HOLD;
         clr_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         rpt_q      <= rpt_d;
         cur_data_q <= cur_data_d;
         cur_func_q <= cur_func_d;
         rdy_q      <= rdy_d;
         data_q     <= data_d;
         func_q     <= func_d;
         clr_q      <= clr_d;
      end
   end

   assign bus.alu_data  = data_q;
   assign bus.alu_func  = func_q;
   assign bus.alu_clear = clr_q;
   assign bus.busy      = !((state_q == ST_IDLE) && (occ == '0));

endmodule
